// File: rtl/intc_benes_cfg_sequencer_pkg.sv
// Shared sizes and types for the Benes interconnect configuration sequencer.
package intc_benes_cfg_sequencer_pkg;

   localparam int STAGE_NUM  = 9;
   localparam int SWITCH_NUM = 16;
   localparam int MID_STAGE  = STAGE_NUM / 2;
   localparam int STAGE_W    = $clog2(STAGE_NUM);

   // sel[k][s] is the select bit of switch k in stage s
   typedef logic [SWITCH_NUM-1:0] [0:STAGE_NUM-1] intc_sel_bank_t;
   typedef logic [SWITCH_NUM-1:0] intc_sel_word_t;

   typedef enum logic {
      SEQ_IDLE,
      SEQ_ROLL
   } seq_state_t;

endpackage

// File: rtl/intc_cfg_bank.sv
// Shadow/active select-word pair for one Benes stage (module and slot banks).
module intc_cfg_bank
   import intc_benes_cfg_sequencer_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           wr_en,
   input  logic           wr_sel,
   input  intc_sel_word_t wr_word,
   input  logic           load,
   output intc_sel_word_t module_word,
   output intc_sel_word_t slot_word
);

   intc_sel_word_t shadow_module;
   intc_sel_word_t shadow_slot;
   logic           wr_module;
   logic           wr_slot;

   assign wr_module = wr_en && !wr_sel;
   assign wr_slot   = wr_en && wr_sel;

   // A write landing in the same cycle as the load is forwarded into the active copy
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_module <= '0;
         shadow_slot   <= '0;
         module_word   <= '0;
         slot_word     <= '0;
      end else begin
         if (wr_module) shadow_module <= wr_word;
         if (wr_slot)   shadow_slot   <= wr_word;
         if (load) begin
            module_word <= wr_module ? wr_word : shadow_module;
            slot_word   <= wr_slot   ? wr_word : shadow_slot;
         end
      end
   end

endmodule

// File: rtl/intc_benes_cfg_sequencer.sv
// Rolls shadow select words into the active Benes routing one stage at a time,
// skewed by STAGE_LAT so every data wave sees a single consistent routing.
module intc_benes_cfg_sequencer
   import intc_benes_cfg_sequencer_pkg::*;
#(
   parameter int STAGE_LAT = 1
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_cfg_wr_en,
   input  logic                 i_cfg_sel,
   input  logic [STAGE_W-1:0]   i_cfg_stage,
   input  logic [SWITCH_NUM-1:0] i_cfg_word,
   output logic                 o_cfg_ready,
   input  logic                 i_commit,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_cfg_err,
   output intc_sel_bank_t       o_module_select,
   output intc_sel_bank_t       o_slot_select
);

   localparam int                 LAT_W      = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGE_NUM - 1);
   localparam logic [LAT_W-1:0]   LAST_LAT   = LAT_W'(STAGE_LAT - 1);

   seq_state_t          state;
   seq_state_t          state_next;
   logic [STAGE_W-1:0]  stage_cnt;
   logic [STAGE_W-1:0]  stage_cnt_next;
   logic [LAT_W-1:0]    lat_cnt;
   logic [LAT_W-1:0]    lat_cnt_next;
   logic                busy;
   logic                commit_go;
   logic                lat_last;
   logic                stage_last;
   logic                stage_valid;
   logic                wr_ok;
   logic                cfg_err;
   logic [STAGE_NUM-1:0] bank_wr;
   logic [STAGE_NUM-1:0] bank_load;
   intc_sel_word_t      module_word [STAGE_NUM];
   intc_sel_word_t      slot_word   [STAGE_NUM];

   assign busy        = (state == SEQ_ROLL);
   assign commit_go   = i_commit && !busy;
   assign lat_last    = (lat_cnt == LAST_LAT);
   assign stage_last  = (stage_cnt == LAST_STAGE);
   assign stage_valid = (i_cfg_stage < STAGE_W'(STAGE_NUM));
   assign wr_ok       = i_cfg_wr_en && !busy && stage_valid;

   assign o_busy      = busy;
   assign o_cfg_ready = !busy;
   assign o_done      = busy && stage_last;
   assign o_cfg_err   = cfg_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SEQ_IDLE;
         stage_cnt <= '0;
         lat_cnt   <= '0;
      end else begin
         state     <= state_next;
         stage_cnt <= stage_cnt_next;
         lat_cnt   <= lat_cnt_next;
      end
   end

   // stage_cnt is the stage whose new value is visible in the current ROLL cycle
   always_comb begin
      state_next     = state;
      stage_cnt_next = stage_cnt;
      lat_cnt_next   = lat_cnt;
      case (state)
         SEQ_IDLE: begin
            if (commit_go) begin
               state_next     = SEQ_ROLL;
               stage_cnt_next = '0;
               lat_cnt_next   = '0;
            end
         end
         SEQ_ROLL: begin
            if (stage_last) begin
               state_next     = SEQ_IDLE;
               stage_cnt_next = '0;
               lat_cnt_next   = '0;
            end else if (lat_last) begin
               stage_cnt_next = stage_cnt + STAGE_W'(1);
               lat_cnt_next   = '0;
            end else begin
               lat_cnt_next   = lat_cnt + LAT_W'(1);
            end
         end
         default: begin
            state_next     = SEQ_IDLE;
            stage_cnt_next = '0;
            lat_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_err <= 1'b0;
      end else if (i_cfg_wr_en && !busy && !stage_valid) begin
         cfg_err <= 1'b1;
      end
   end

   // Stage 0 loads on the commit edge; stage s loads when stage s-1 has aged STAGE_LAT cycles
   for (genvar s = 0; s < STAGE_NUM; s++) begin : g_stage
      assign bank_wr[s] = wr_ok && (i_cfg_stage == STAGE_W'(s));
      if (s == 0) begin : g_first
         assign bank_load[s] = commit_go;
      end else begin : g_rest
         assign bank_load[s] = busy && lat_last && (stage_cnt == STAGE_W'(s - 1));
      end

      intc_cfg_bank u_bank (
         .clk         (clk),
         .rst         (rst),
         .wr_en       (bank_wr[s]),
         .wr_sel      (i_cfg_sel),
         .wr_word     (i_cfg_word),
         .load        (bank_load[s]),
         .module_word (module_word[s]),
         .slot_word   (slot_word[s])
      );
   end

   always_comb begin
      o_module_select = '0;
      o_slot_select   = '0;
      for (int s = 0; s < STAGE_NUM; s++) begin
         for (int k = 0; k < SWITCH_NUM; k++) begin
            o_module_select[k][s] = module_word[s][k];
            o_slot_select[k][s]   = slot_word[s][k];
         end
      end
   end

endmodule

// File: tb/tb_intc_benes_cfg_sequencer.sv
// Randomized bench for the Benes config sequencer, two instances (STAGE_LAT 1 and 2)
// sharing one stimulus stream and checked against a cycle-age reference model.
module tb_intc_benes_cfg_sequencer;
   import intc_benes_cfg_sequencer_pkg::*;

   localparam int NI = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  cfg_wr_en;
   logic                  cfg_sel;
   logic [STAGE_W-1:0]    cfg_stage;
   logic [SWITCH_NUM-1:0] cfg_word;
   logic                  commit;

   logic           ready_a, busy_a, done_a, err_a;
   logic           ready_b, busy_b, done_b, err_b;
   intc_sel_bank_t module_a, slot_a, module_b, slot_b;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [SWITCH_NUM-1:0] m_shadow [NI][2][STAGE_NUM];
   logic [SWITCH_NUM-1:0] m_snap   [NI][2][STAGE_NUM];
   logic [SWITCH_NUM-1:0] m_active [NI][2][STAGE_NUM];
   int                    m_age    [NI];
   bit                    m_err    [NI];

   intc_benes_cfg_sequencer #(.STAGE_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .i_cfg_wr_en(cfg_wr_en), .i_cfg_sel(cfg_sel),
      .i_cfg_stage(cfg_stage), .i_cfg_word(cfg_word), .o_cfg_ready(ready_a),
      .i_commit(commit), .o_busy(busy_a), .o_done(done_a), .o_cfg_err(err_a),
      .o_module_select(module_a), .o_slot_select(slot_a)
   );

   intc_benes_cfg_sequencer #(.STAGE_LAT(2)) dut_b (
      .clk(clk), .rst(rst), .i_cfg_wr_en(cfg_wr_en), .i_cfg_sel(cfg_sel),
      .i_cfg_stage(cfg_stage), .i_cfg_word(cfg_word), .o_cfg_ready(ready_b),
      .i_commit(commit), .o_busy(busy_b), .o_done(done_b), .o_cfg_err(err_b),
      .o_module_select(module_b), .o_slot_select(slot_b)
   );

   always #5 clk = ~clk;

   function automatic logic [SWITCH_NUM-1:0] stageWord(intc_sel_bank_t b, int s);
      logic [SWITCH_NUM-1:0] w;
      for (int k = 0; k < SWITCH_NUM; k++) w[k] = b[k][s];
      return w;
   endfunction

   task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: observed %h required %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Model: age = cycles since the accepting commit; stage s takes its snapshot at age s*lat
   task automatic modelStep(int i, bit r, bit we, bit sel, int stg, logic [SWITCH_NUM-1:0] w, bit cm);
      int lat;
      int last;
      lat  = i + 1;
      last = (STAGE_NUM - 1) * lat + 1;
      if (r) begin
         for (int b = 0; b < 2; b++)
            for (int s = 0; s < STAGE_NUM; s++) begin
               m_shadow[i][b][s] = '0;
               m_snap[i][b][s]   = '0;
               m_active[i][b][s] = '0;
            end
         m_age[i] = -1;
         m_err[i] = 1'b0;
         return;
      end
      if (m_age[i] < 0) begin
         if (we) begin
            if (stg < STAGE_NUM) m_shadow[i][sel][stg] = w;
            else                 m_err[i] = 1'b1;
         end
         if (cm) begin
            for (int b = 0; b < 2; b++)
               for (int s = 0; s < STAGE_NUM; s++) m_snap[i][b][s] = m_shadow[i][b][s];
            m_age[i] = 0;
         end
      end
      if (m_age[i] >= 0) begin
         for (int s = 0; s < STAGE_NUM; s++)
            if (m_age[i] == s * lat) begin
               m_active[i][0][s] = m_snap[i][0][s];
               m_active[i][1][s] = m_snap[i][1][s];
            end
         m_age[i]++;
         if (m_age[i] > last) m_age[i] = -1;
      end
   endtask

   task automatic checkInstance(int i, intc_sel_bank_t mod, intc_sel_bank_t slot,
                                logic bsy, logic dn, logic rdy, logic er);
      int lat;
      bit exp_busy;
      bit exp_done;
      lat      = i + 1;
      exp_busy = (m_age[i] >= 1);
      exp_done = (m_age[i] == (STAGE_NUM - 1) * lat + 1);
      checkOutput($sformatf("L%0d busy", lat),  32'(bsy), 32'(exp_busy));
      checkOutput($sformatf("L%0d done", lat),  32'(dn),  32'(exp_done));
      checkOutput($sformatf("L%0d ready", lat), 32'(rdy), 32'(!exp_busy));
      checkOutput($sformatf("L%0d err", lat),   32'(er),  32'(m_err[i]));
      for (int s = 0; s < STAGE_NUM; s++) begin
         checkOutput($sformatf("L%0d module s%0d", lat, s), 32'(stageWord(mod, s)),  32'(m_active[i][0][s]));
         checkOutput($sformatf("L%0d slot s%0d", lat, s),   32'(stageWord(slot, s)), 32'(m_active[i][1][s]));
      end
   endtask

   task automatic applyStimulus(bit r, bit we, bit sel, int stg, logic [SWITCH_NUM-1:0] w, bit cm);
      rst       = r;
      cfg_wr_en = we;
      cfg_sel   = sel;
      cfg_stage = STAGE_W'(stg);
      cfg_word  = w;
      commit    = cm;
      @(posedge clk);
      for (int i = 0; i < NI; i++) modelStep(i, r, we, sel, stg, w, cm);
      #1;
      checkInstance(0, module_a, slot_a, busy_a, done_a, ready_a, err_a);
      checkInstance(1, module_b, slot_b, busy_b, done_b, ready_b, err_b);
   endtask

   task automatic idleCycles(int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
   endtask

   initial begin
      bit                    r, we, sel, cm;
      int                    stg;
      logic [SWITCH_NUM-1:0] w;

      rst = 1'b1; cfg_wr_en = 1'b0; cfg_sel = 1'b0; cfg_stage = '0; cfg_word = '0; commit = 1'b0;
      for (int i = 0; i < NI; i++) begin
         m_age[i] = -1;
         m_err[i] = 1'b0;
      end

      applyStimulus(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);

      applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'hA5A5, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 8, 16'h00FF, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
      idleCycles(20);

      applyStimulus(1'b0, 1'b1, 1'b0, 3, 16'h1111, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
      idleCycles(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 3, 16'hFFFF, 1'b0);
      idleCycles(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
      idleCycles(20);

      applyStimulus(1'b0, 1'b1, 1'b1, 12, 16'hBEEF, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
      idleCycles(20);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
      idleCycles(20);

      applyStimulus(1'b0, 1'b1, 1'b0, 4, 16'h1234, 1'b1);
      idleCycles(2);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
      idleCycles(3);

      // Held commit level re-commits back to back
      applyStimulus(1'b0, 1'b1, 1'b1, 7, 16'hC3C3, 1'b0);
      repeat (40) applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
      idleCycles(20);

      repeat (600) begin
         r   = ($urandom_range(0, 149) == 0);
         we  = 1'($urandom_range(0, 1));
         sel = 1'($urandom_range(0, 1));
         stg = ($urandom_range(0, 19) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
         w   = SWITCH_NUM'($urandom);
         cm  = ($urandom_range(0, 4) == 0);
         applyStimulus(r, we, sel, stg, w, cm);
      end
      idleCycles(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
